// File: rtl/uart_rx_wb_slave.sv
// UART 8N1 receiver with RX FIFO, exposed through a Wishbone B4 classic slave.
// Bus outputs are zero unless this slave is acknowledging, so they can be OR-combined.
module uart_rx_wb_slave #(
    parameter int          CLK_FREQ_HZ = 50000000,
    parameter int          BAUD        = 115200,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    output logic        ack_o,
    output logic        err_o,
    output logic        rty_o,
    input  logic        uart_rx
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW           = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    // ------------------------------------------------------------------
    // RX synchroniser and bit-level FSM
    // ------------------------------------------------------------------
    logic             rx_meta;
    logic             rx_s;
    logic [2:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    bit_cnt <= '0;
                    if (!rx_s) state <= S_START;
                end
                S_START: begin
                    if (bit_cnt == MID_CNT) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_cnt == LAST_CNT) begin
                        bit_cnt <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= S_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_cnt == LAST_CNT) begin
                        bit_cnt <= '0;
                        state   <= rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic stop_hit;
    logic push_req;
    logic frame_bad;
    assign stop_hit  = (state == S_STOP) && (bit_cnt == LAST_CNT);
    assign push_req  = stop_hit & rx_s;
    assign frame_bad = stop_hit & ~rx_s;

    // ------------------------------------------------------------------
    // Wishbone decode
    // ------------------------------------------------------------------
    logic       hit;
    logic       acc;
    logic       legal;
    logic [1:0] reg_sel;

    assign reg_sel = addr_i[3:2];
    assign hit     = cyc_i & stb_i & (addr_i[31:4] == BASE_ADDR[31:4]);
    assign acc     = hit & ~ack_o & ~err_o;
    assign legal   = ((reg_sel == 2'd0) & ~we_i) | (reg_sel == 2'd1);

    // ------------------------------------------------------------------
    // FIFO and sticky flags
    // ------------------------------------------------------------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          ovr_set;
    logic          overrun;
    logic          framing_err;
    logic          clr_ovr;
    logic          clr_frm;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop     = acc & (reg_sel == 2'd0) & ~we_i & ~empty;
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    assign push    = push_req & (~full | pop);
    assign ovr_set = push_req & full & ~pop;
    assign clr_ovr = acc & (reg_sel == 2'd1) & we_i & dat_i[2];
    assign clr_frm = acc & (reg_sel == 2'd1) & we_i & dat_i[3];

    // NOTE: the storage array has no reset; count/pointers define validity,
    // which keeps it mappable to plain RAM.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overrun     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overrun     <= (overrun & ~clr_ovr) | ovr_set;
            framing_err <= (framing_err & ~clr_frm) | frame_bad;
        end
    end

    // ------------------------------------------------------------------
    // Read mux and registered response
    // ------------------------------------------------------------------
    logic [8:0]  count_ext;
    logic [31:0] status;
    logic [31:0] rd_data;

    assign count_ext = 9'(count);
    assign status    = {19'd0, count_ext, framing_err, overrun, full, ~empty};

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            2'd0:    rd_data = empty ? 32'd0 : {24'd0, mem[rd_ptr]};
            2'd1:    rd_data = status;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_o <= acc & legal;
            err_o <= acc & ~legal;
            dat_o <= (acc & legal & ~we_i) ? rd_data : 32'd0;
        end
    end

    assign rty_o = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{sel_i, dat_i[31:4], dat_i[1:0], addr_i[1:0]};

endmodule

// File: tb/tb_uart_rx_wb_slave.sv
// Directed bench for uart_rx_wb_slave: a byte queue plus flag model predicts every
// RXDATA/STATUS read; the baud rate is scaled so a bit lasts 64 clocks.
`timescale 1ns/1ps
module tb_uart_rx_wb_slave;

    localparam int          CPB   = 64;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_2000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] addr_i = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        we_i = 1'b0;
    logic [3:0]  sel_i = 4'hF;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        ack_o;
    logic        err_o;
    logic        rty_o;
    logic        uart_rx = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];
    logic       exp_ovr = 1'b0;
    logic       exp_frm = 1'b0;

    uart_rx_wb_slave #(
        .CLK_FREQ_HZ(100_000_000),
        .BAUD       (1_562_500),
        .FIFO_DEPTH (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .addr_i (addr_i),
        .dat_i  (dat_i),
        .dat_o  (dat_o),
        .we_i   (we_i),
        .sel_i  (sel_i),
        .cyc_i  (cyc_i),
        .stb_i  (stb_i),
        .ack_o  (ack_o),
        .err_o  (err_o),
        .rty_o  (rty_o),
        .uart_rx(uart_rx)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [8:0] c;
        c = 9'(exp_q.size());
        return {19'd0, c, exp_frm, exp_ovr, exp_q.size() == DEPTH, exp_q.size() != 0};
    endfunction

    // One bus transfer; waits at most 4 cycles for a response.
    task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                       output logic [31:0] rd, output logic ak, output logic er,
                       output int lat, output logic [31:0] seen);
        @(posedge clk_i); #1;
        addr_i = a; we_i = w; dat_i = d; cyc_i = 1'b1; stb_i = 1'b1;
        rd = '0; ak = 1'b0; er = 1'b0; lat = 0; seen = '0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk_i); #1;
            seen = seen | dat_o | {29'd0, rty_o, err_o, ack_o};
            if (ack_o || err_o) begin
                ak = ack_o; er = err_o; rd = dat_o; lat = i;
                break;
            end
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; dat_i = '0;
    endtask

    task automatic read_chk(input logic [3:0] off, input logic [31:0] exp, input string tag);
        logic [31:0] rd, seen;
        logic ak, er;
        int lat;
        bus(BASE + 32'(off), 1'b0, '0, rd, ak, er, lat, seen);
        check({tag, "_ack"}, {31'd0, ak}, 32'd1);
        check({tag, "_data"}, rd, exp);
    endtask

    task automatic read_status(input string tag);
        read_chk(4'h4, exp_status(), tag);
    endtask

    task automatic read_data(input string tag);
        logic [31:0] exp;
        exp = (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'd0;
        read_chk(4'h0, exp, tag);
    endtask

    task automatic write_status(input logic [31:0] d, input string tag);
        logic [31:0] rd, seen;
        logic ak, er;
        int lat;
        bus(BASE + 32'h4, 1'b1, d, rd, ak, er, lat, seen);
        check({tag, "_ack"}, {31'd0, ak}, 32'd1);
        if (d[2]) exp_ovr = 1'b0;
        if (d[3]) exp_frm = 1'b0;
    endtask

    task automatic expect_err(input logic [31:0] a, input logic w, input string tag);
        logic [31:0] rd, seen;
        logic ak, er;
        int lat;
        bus(a, w, 32'hFFFF_FFFF, rd, ak, er, lat, seen);
        check({tag, "_err"}, {30'd0, er, ak}, 32'b10);
        check({tag, "_lat"}, 32'(lat), 32'd1);
    endtask

    task automatic uart_bit(input logic b);
        #1 uart_rx = b;
        repeat (CPB) @(posedge clk_i);
    endtask

    // Sends one frame; a good stop bit means the model expects a push or an overrun.
    task automatic uart_send(input logic [7:0] b, input logic stop);
        uart_bit(1'b0);
        for (int i = 0; i < 8; i++) uart_bit(b[i]);
        uart_bit(stop);
        if (stop) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else exp_ovr = 1'b1;
        end else begin
            exp_frm = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] rd, seen;
        logic ak, er;
        int lat;

        // 1. reset state and empty reads
        repeat (4) @(posedge clk_i);
        #1 rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_outputs", {dat_o[30:0], ack_o, err_o, rty_o}, 34'd0 >> 0);
        bus(BASE + 32'h4, 1'b0, '0, rd, ak, er, lat, seen);
        check("rst_status_lat", 32'(lat), 32'd1);
        check("rst_status", rd, exp_status());
        read_data("empty_rxdata");
        read_status("empty_after_pop");

        // 2. single byte
        uart_send(8'hA5, 1'b1);
        read_status("a5_status");
        read_data("a5_rxdata");
        read_status("a5_drained");

        // 3. fill past full, drain in order, clear overrun
        for (int i = 0; i < 17; i++) uart_send(8'(i), 1'b1);
        check("full_model", exp_status(), 32'h0000_0107);
        read_status("full_status");
        for (int i = 0; i < 16; i++) read_data($sformatf("drain_%0d", i));
        read_status("drained_status");
        write_status(32'h4, "clr_ovr");
        read_status("ovr_cleared");

        // 4. framing error followed by a line break, then a good byte
        uart_send(8'h3C, 1'b0);
        uart_bit(1'b0);
        uart_bit(1'b0);
        uart_bit(1'b1);
        uart_send(8'h55, 1'b1);
        read_status("frm_status");
        read_data("frm_rxdata");
        write_status(32'h8, "clr_frm");
        read_status("frm_cleared");

        // 5. short low glitch on an idle line, then prove the FSM is idle again
        #1 uart_rx = 1'b0;
        #200;
        uart_rx = 1'b1;
        repeat (3 * CPB) @(posedge clk_i);
        read_status("glitch_status");
        uart_send(8'h5A, 1'b1);
        read_data("post_glitch_rxdata");

        // 6. illegal accesses leave state alone; out-of-window is silent
        uart_send(8'h77, 1'b1);
        expect_err(BASE + 32'h0, 1'b1, "wr_rxdata");
        expect_err(BASE + 32'h8, 1'b0, "rd_0x8");
        expect_err(BASE + 32'hC, 1'b1, "wr_0xc");
        read_status("after_err_status");
        bus(BASE + 32'h10, 1'b0, '0, rd, ak, er, lat, seen);
        check("unaddressed_outputs", seen, 32'd0);
        read_data("after_err_rxdata");

        // reset mid-frame with a byte already buffered
        uart_send(8'h99, 1'b1);
        uart_bit(1'b0);
        uart_bit(1'b1);
        uart_bit(1'b0);
        #3 rst_i = 1'b1;
        exp_q.delete();
        exp_ovr = 1'b0;
        exp_frm = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        repeat (2 * CPB) @(posedge clk_i);
        read_status("post_rst_status");
        uart_send(8'hC3, 1'b1);
        read_status("post_rst_frame_status");
        read_data("post_rst_rxdata");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
